// File: rtl/mux_2_1_sel_arb.sv
// Round-robin select generator for a 2:1 mux: grants A or B, caps how long one
// side may hold the mux while the other waits, and drives a registered select S.
module mux_2_1_sel_arb #(
  parameter int HOLD_MAX = 4,
  parameter int CNT_W    = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             REQ_A,
  input  logic             REQ_B,
  output logic             S,
  output logic             GNT_A,
  output logic             GNT_B,
  output logic             BUSY,
  output logic [CNT_W-1:0] HOLD_CNT
);

  typedef enum logic [1:0] {IDLE, GRANT_A, GRANT_B} state_t;
  typedef enum logic {SIDE_A, SIDE_B} side_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOLD_MAX - 1);

  state_t           state, state_nxt;
  side_t            last, last_nxt;
  logic             s_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             at_cap;

  assign at_cap = (HOLD_CNT == CNT_MAX);

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_nxt = state;
    last_nxt  = last;
    s_nxt     = S;
    cnt_nxt   = '0;

    unique case (state)
      IDLE: begin
        if (REQ_A && REQ_B)  state_nxt = (last == SIDE_A) ? GRANT_B : GRANT_A;
        else if (REQ_A)      state_nxt = GRANT_A;
        else if (REQ_B)      state_nxt = GRANT_B;
      end
      GRANT_A: begin
        if (!REQ_A)          state_nxt = REQ_B ? GRANT_B : IDLE;
        else if (REQ_B && at_cap) state_nxt = GRANT_B;
      end
      GRANT_B: begin
        if (!REQ_B)          state_nxt = REQ_A ? GRANT_A : IDLE;
        else if (REQ_A && at_cap) state_nxt = GRANT_A;
      end
      default:               state_nxt = IDLE;
    endcase

    // Counter restarts on any grant entry and saturates while the owner stays.
    if (state_nxt != IDLE && state_nxt == state)
      cnt_nxt = at_cap ? HOLD_CNT : HOLD_CNT + 1'b1;

    // S is left untouched in IDLE so the mux output does not flip needlessly.
    if (state_nxt == GRANT_A) s_nxt = 1'b0;
    if (state_nxt == GRANT_B) s_nxt = 1'b1;

    if (state_nxt != state && state_nxt == GRANT_A) last_nxt = SIDE_A;
    if (state_nxt != state && state_nxt == GRANT_B) last_nxt = SIDE_B;
  end

  // NOTE: state is updated with non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      last     <= SIDE_B;
      S        <= 1'b0;
      GNT_A    <= 1'b0;
      GNT_B    <= 1'b0;
      BUSY     <= 1'b0;
      HOLD_CNT <= '0;
    end else begin
      state    <= state_nxt;
      last     <= last_nxt;
      S        <= s_nxt;
      GNT_A    <= (state_nxt == GRANT_A);
      GNT_B    <= (state_nxt == GRANT_B);
      BUSY     <= (state_nxt != IDLE);
      HOLD_CNT <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_mux_2_1_sel_arb.sv
// Directed bench for mux_2_1_sel_arb (HOLD_MAX=4, CNT_W=2): hand-computed
// expectations checked with immediate assertions after each clock edge.
module tb_mux_2_1_sel_arb;

  logic       CLK = 1'b0;
  logic       RST;
  logic       REQ_A, REQ_B;
  logic       S, GNT_A, GNT_B, BUSY;
  logic [1:0] HOLD_CNT;

  int total = 0;
  int bad   = 0;

  mux_2_1_sel_arb #(.HOLD_MAX(4), .CNT_W(2)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .REQ_A    (REQ_A),
    .REQ_B    (REQ_B),
    .S        (S),
    .GNT_A    (GNT_A),
    .GNT_B    (GNT_B),
    .BUSY     (BUSY),
    .HOLD_CNT (HOLD_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Expected vector layout: {GNT_A, GNT_B, BUSY, S, HOLD_CNT}
  function automatic logic [5:0] ev(input logic ga, input logic gb, input logic s,
                                    input logic [1:0] cnt);
    return {ga, gb, ga | gb, s, cnt};
  endfunction

  task automatic check(input string tag, input logic [5:0] exp);
    logic [5:0] obs;
    obs = {GNT_A, GNT_B, BUSY, S, HOLD_CNT};
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed gnt_a/gnt_b/busy/s/cnt=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    // 1. reset overrides a tie; first cycle after release grants A
    RST = 1'b1; REQ_A = 1'b1; REQ_B = 1'b1;
    tick();
    tick();
    check("reset_all_zero", ev(0, 0, 0, 2'd0));
    RST = 1'b0;
    tick();
    check("first_tie_to_a", ev(1, 0, 0, 2'd0));

    REQ_A = 1'b0; REQ_B = 1'b0;
    tick();
    check("idle_after_a", ev(0, 0, 0, 2'd0));

    // 2. B alone for three cycles, then idle with S held at 1
    REQ_B = 1'b1;
    tick(); check("b_only_c0", ev(0, 1, 1, 2'd0));
    tick(); check("b_only_c1", ev(0, 1, 1, 2'd1));
    tick(); check("b_only_c2", ev(0, 1, 1, 2'd2));
    REQ_B = 1'b0;
    tick(); check("idle_s_held", ev(0, 0, 1, 2'd0));
    tick(); check("idle_s_held2", ev(0, 0, 1, 2'd0));

    // 3. continuous contention: A4, B4, A4, B4 (last served was B)
    REQ_A = 1'b1; REQ_B = 1'b1;
    for (int i = 0; i < 16; i++) begin
      logic on_b;
      on_b = ((i / 4) % 2) == 1;
      tick();
      check($sformatf("contend_%0d", i), ev(!on_b, on_b, on_b, 2'(i % 4)));
    end

    // 4. A alone: direct handoff from B, then held indefinitely with saturating count
    REQ_B = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("a_only_%0d", i), ev(1, 0, 0, (i > 3) ? 2'd3 : 2'(i)));
    end

    // 5. handoff from GRANT_A at HOLD_CNT=1 straight to B
    REQ_A = 1'b0;
    tick(); check("idle_s0", ev(0, 0, 0, 2'd0));
    REQ_A = 1'b1;
    tick(); check("a_c0", ev(1, 0, 0, 2'd0));
    tick(); check("a_c1", ev(1, 0, 0, 2'd1));
    REQ_A = 1'b0; REQ_B = 1'b1;
    tick(); check("handoff_to_b", ev(0, 1, 1, 2'd0));

    // 6. reset mid-grant at HOLD_CNT=2, then a tie goes to A
    tick(); check("b_c1", ev(0, 1, 1, 2'd1));
    tick(); check("b_c2", ev(0, 1, 1, 2'd2));
    RST = 1'b1; REQ_A = 1'b1;
    tick(); check("reset_mid_grant", ev(0, 0, 0, 2'd0));
    RST = 1'b0;
    tick(); check("tie_after_reset", ev(1, 0, 0, 2'd0));

    // Tie from IDLE after A was served goes to B
    REQ_A = 1'b0; REQ_B = 1'b0;
    tick(); check("idle_last_a", ev(0, 0, 0, 2'd0));
    REQ_A = 1'b1; REQ_B = 1'b1;
    tick(); check("tie_to_b", ev(0, 1, 1, 2'd0));
    tick(); check("tie_to_b_c1", ev(0, 1, 1, 2'd1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
